// File: rtl/control_unit_if.sv
// Control bundle between the main control FSM and the datapath.
// The datapath holds op/func/stop_bit stable from DECODE until the instruction completes.
interface control_unit_if;
  logic [4:0] func;
  logic [1:0] op;
  logic       stop_bit;
  logic       zero;
  logic [1:0] PCSrc;
  logic       StackRd;
  logic       StackWr;
  logic       RegWr;
  logic       RegSrc;
  logic       ExtOp;
  logic [3:0] ALUOp;
  logic [1:0] ALUSrc;
  logic       MemWr;
  logic       MemRd;
  logic       WBData;

  modport master (
    input  func, op, stop_bit, zero,
    output PCSrc, StackRd, StackWr, RegWr, RegSrc, ExtOp, ALUOp, ALUSrc,
           MemWr, MemRd, WBData
  );

  modport slave (
    output func, op, stop_bit, zero,
    input  PCSrc, StackRd, StackWr, RegWr, RegSrc, ExtOp, ALUOp, ALUSrc,
           MemWr, MemRd, WBData
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing for the RISC core.
// state_dbg exposes the state register (FETCH=0 .. WB=4).
module control_unit (
  input  logic                 clk,
  input  logic                 reset,
  control_unit_if.master       bus,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [1:0] OP_R = 2'b00, OP_I = 2'b01, OP_J = 2'b10, OP_S = 2'b11;
  localparam logic [1:0] PC_HOLD = 2'b00, PC_INC = 2'b01, PC_OFF = 2'b10, PC_STACK = 2'b11;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_ADD = 4'b0001, ALU_SUB = 4'b0010,
                         ALU_SLL = 4'b0011, ALU_SRL = 4'b0100;
  localparam logic [1:0] SRC_REG = 2'b00, SRC_IMM = 2'b01, SRC_SHAMT = 2'b10;

  state_t state, next_state;

  logic       valid, is_jump, is_beq, is_cmp, is_lw, is_sw;
  logic       d_regsrc, d_ext, d_wb;
  logic [3:0] d_aluop;
  logic [1:0] d_alusrc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  assign state_dbg = state;

  // Instruction decode; undefined op/func leaves valid low and every field zero.
  always_comb begin
    valid    = 1'b0;
    is_jump  = 1'b0;
    is_beq   = 1'b0;
    is_cmp   = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    d_regsrc = 1'b0;
    d_ext    = 1'b0;
    d_wb     = 1'b0;
    d_aluop  = ALU_AND;
    d_alusrc = SRC_REG;
    case (bus.op)
      OP_R: begin
        case (bus.func)
          5'd0: valid = 1'b1;
          5'd1: begin valid = 1'b1; d_aluop = ALU_ADD; end
          5'd2: begin valid = 1'b1; d_aluop = ALU_SUB; end
          5'd3: begin valid = 1'b1; d_aluop = ALU_SUB; is_cmp = 1'b1; end
          default: ;
        endcase
      end
      OP_I: begin
        case (bus.func)
          5'd0: begin valid = 1'b1; d_alusrc = SRC_IMM; end
          5'd1: begin valid = 1'b1; d_ext = 1'b1; d_aluop = ALU_ADD; d_alusrc = SRC_IMM; end
          5'd2: begin
            valid = 1'b1; is_lw = 1'b1; d_ext = 1'b1;
            d_aluop = ALU_ADD; d_alusrc = SRC_IMM; d_wb = 1'b1;
          end
          5'd3: begin
            valid = 1'b1; is_sw = 1'b1; d_ext = 1'b1; d_regsrc = 1'b1;
            d_aluop = ALU_ADD; d_alusrc = SRC_IMM;
          end
          5'd4: begin valid = 1'b1; is_beq = 1'b1; d_regsrc = 1'b1; d_aluop = ALU_SUB; end
          default: ;
        endcase
      end
      OP_J: begin
        if (bus.func <= 5'd2) begin
          valid   = 1'b1;
          is_jump = 1'b1;
        end
      end
      OP_S: begin
        case (bus.func)
          5'd0: begin valid = 1'b1; d_aluop = ALU_SLL; d_alusrc = SRC_SHAMT; end
          5'd1: begin valid = 1'b1; d_aluop = ALU_SRL; d_alusrc = SRC_SHAMT; end
          5'd2: begin valid = 1'b1; d_aluop = ALU_SLL; end
          5'd3: begin valid = 1'b1; d_aluop = ALU_SRL; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Next state and datapath controls; completion either steps the PC or returns via the stack.
  always_comb begin
    next_state  = state;
    bus.PCSrc   = PC_HOLD;
    bus.StackRd = 1'b0;
    bus.StackWr = 1'b0;
    bus.RegWr   = 1'b0;
    bus.MemWr   = 1'b0;
    bus.MemRd   = 1'b0;
    bus.RegSrc  = 1'b0;
    bus.ExtOp   = 1'b0;
    bus.ALUOp   = ALU_AND;
    bus.ALUSrc  = SRC_REG;
    bus.WBData  = 1'b0;

    if (state != FETCH) begin
      bus.RegSrc = d_regsrc;
      bus.ExtOp  = d_ext;
      bus.ALUOp  = d_aluop;
      bus.ALUSrc = d_alusrc;
      bus.WBData = d_wb;
    end

    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        if (!valid) begin
          bus.PCSrc  = PC_INC;
          next_state = FETCH;
        end else if (is_jump) begin
          next_state = FETCH;
          case (bus.func[1:0])
            2'd0: bus.PCSrc = PC_OFF;
            2'd1: begin bus.PCSrc = PC_OFF; bus.StackWr = 1'b1; end
            default: begin bus.PCSrc = PC_STACK; bus.StackRd = 1'b1; end
          endcase
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (is_beq) begin
          bus.PCSrc  = bus.zero ? PC_OFF : PC_INC;
          next_state = FETCH;
        end else if (is_cmp) begin
          bus.PCSrc   = bus.stop_bit ? PC_STACK : PC_INC;
          bus.StackRd = bus.stop_bit;
          next_state  = FETCH;
        end else if (is_lw || is_sw) begin
          next_state = MEM;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        if (is_lw) begin
          bus.MemRd  = 1'b1;
          next_state = WB;
        end else begin
          bus.MemWr   = 1'b1;
          bus.PCSrc   = bus.stop_bit ? PC_STACK : PC_INC;
          bus.StackRd = bus.stop_bit;
          next_state  = FETCH;
        end
      end
      WB: begin
        bus.RegWr   = 1'b1;
        bus.PCSrc   = bus.stop_bit ? PC_STACK : PC_INC;
        bus.StackRd = bus.stop_bit;
        next_state  = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected control vectors for each instruction class.
module tb_control_unit;
  localparam int W = 19;
  localparam logic [4:0] S_NONE = 5'b00000, S_SRD = 5'b10000, S_SWR = 5'b01000,
                         S_RWR = 5'b00100, S_MWR = 5'b00010, S_MRD = 5'b00001;

  logic         clk;
  logic         reset;
  logic [2:0]   state_dbg;
  logic [W-1:0] obs;
  logic [W-1:0] exp_v;
  logic [W-1:0] exp_q[$];
  int           passed;
  int           total;

  control_unit_if bus();

  control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {state, PCSrc, StackRd, StackWr, RegWr, MemWr, MemRd, RegSrc, ExtOp, ALUOp, ALUSrc, WBData}
  assign obs = {state_dbg, bus.PCSrc, bus.StackRd, bus.StackWr, bus.RegWr, bus.MemWr,
                bus.MemRd, bus.RegSrc, bus.ExtOp, bus.ALUOp, bus.ALUSrc, bus.WBData};

  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [1:0] pc,
                                      input logic [4:0] stb, input logic rs, input logic ext,
                                      input logic [3:0] alu, input logic [1:0] src,
                                      input logic wbd);
    return {st, pc, stb, rs, ext, alu, src, wbd};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [4:0] func, input logic stop,
                       input logic zero);
    bus.op       = op;
    bus.func     = func;
    bus.stop_bit = stop;
    bus.zero     = zero;
  endtask

  task automatic test_reset;
    drive(2'b01, 5'd1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(posedge clk);
      #2;
      total++;
      if (obs !== '0) $display("FAIL reset cycle %0d: got %h expected %h", i, obs, '0);
      else passed++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (obs !== '0) $display("FAIL reset_release: got %h expected %h", obs, '0);
    else passed++;
  endtask

  task automatic test_addi;
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd1, 2'd0, S_NONE, 1'b0, 1'b1, 4'd1, 2'd1, 1'b0));
    exp_q.push_back(mk(3'd2, 2'd0, S_NONE, 1'b0, 1'b1, 4'd1, 2'd1, 1'b0));
    exp_q.push_back(mk(3'd4, 2'd1, S_RWR,  1'b0, 1'b1, 4'd1, 2'd1, 1'b0));
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    drive(2'b01, 5'd1, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(posedge clk);
      #2;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL addi cycle %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_lw_sw;
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd1, 2'd0, S_NONE, 1'b0, 1'b1, 4'd1, 2'd1, 1'b1));
    exp_q.push_back(mk(3'd2, 2'd0, S_NONE, 1'b0, 1'b1, 4'd1, 2'd1, 1'b1));
    exp_q.push_back(mk(3'd3, 2'd0, S_MRD,  1'b0, 1'b1, 4'd1, 2'd1, 1'b1));
    exp_q.push_back(mk(3'd4, 2'd1, S_RWR,  1'b0, 1'b1, 4'd1, 2'd1, 1'b1));
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    drive(2'b01, 5'd2, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(posedge clk);
      #2;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL lw cycle %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
    end
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd1, 2'd0, S_NONE, 1'b1, 1'b1, 4'd1, 2'd1, 1'b0));
    exp_q.push_back(mk(3'd2, 2'd0, S_NONE, 1'b1, 1'b1, 4'd1, 2'd1, 1'b0));
    exp_q.push_back(mk(3'd3, 2'd1, S_MWR,  1'b1, 1'b1, 4'd1, 2'd1, 1'b0));
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    drive(2'b01, 5'd3, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(posedge clk);
      #2;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL sw cycle %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
      exp_q.push_back(mk(3'd1, 2'd0, S_NONE, 1'b1, 1'b0, 4'd2, 2'd0, 1'b0));
      exp_q.push_back(mk(3'd2, (z == 1) ? 2'd2 : 2'd1, S_NONE, 1'b1, 1'b0, 4'd2, 2'd0, 1'b0));
      exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
      drive(2'b01, 5'd4, 1'b1, z[0]);
      for (int i = 0; exp_q.size() > 0; i++) begin
        if (i > 0) @(posedge clk);
        #2;
        exp_v = exp_q.pop_front();
        total++;
        if (obs !== exp_v) $display("FAIL beq zero=%0d cycle %0d: got %h expected %h", z, i, obs, exp_v);
        else passed++;
      end
    end
  endtask

  task automatic test_jumps;
    logic [1:0] pc_tab [3];
    logic [4:0] stb_tab [3];
    pc_tab  = '{2'd2, 2'd2, 2'd3};
    stb_tab = '{S_NONE, S_SWR, S_SRD};
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
      exp_q.push_back(mk(3'd1, pc_tab[f], stb_tab[f], 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
      exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
      drive(2'b10, 5'(f), 1'b1, 1'b0);
      for (int i = 0; exp_q.size() > 0; i++) begin
        if (i > 0) @(posedge clk);
        #2;
        exp_v = exp_q.pop_front();
        total++;
        if (obs !== exp_v) $display("FAIL jump func=%0d cycle %0d: got %h expected %h", f, i, obs, exp_v);
        else passed++;
      end
    end
  endtask

  task automatic test_stop_bit;
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd1, 2'd0, S_NONE, 1'b0, 1'b0, 4'd1, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd2, 2'd0, S_NONE, 1'b0, 1'b0, 4'd1, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd4, 2'd3, S_SRD | S_RWR, 1'b0, 1'b0, 4'd1, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    drive(2'b00, 5'd1, 1'b1, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(posedge clk);
      #2;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL add_stop cycle %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
    end
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd1, 2'd0, S_NONE, 1'b0, 1'b0, 4'd2, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd2, 2'd3, S_SRD,  1'b0, 1'b0, 4'd2, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    drive(2'b00, 5'd3, 1'b1, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(posedge clk);
      #2;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL cmp_stop cycle %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_shift_nop;
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd1, 2'd0, S_NONE, 1'b0, 1'b0, 4'd3, 2'd2, 1'b0));
    exp_q.push_back(mk(3'd2, 2'd0, S_NONE, 1'b0, 1'b0, 4'd3, 2'd2, 1'b0));
    exp_q.push_back(mk(3'd4, 2'd1, S_RWR,  1'b0, 1'b0, 4'd3, 2'd2, 1'b0));
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd1, 2'd1, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    drive(2'b11, 5'd0, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(posedge clk);
      if (i == 4) drive(2'b00, 5'd31, 1'b0, 1'b0);
      #2;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL sll_nop cycle %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd1, 2'd0, S_NONE, 1'b0, 1'b0, 4'd1, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd2, 2'd0, S_NONE, 1'b0, 1'b0, 4'd1, 2'd0, 1'b0));
    drive(2'b00, 5'd1, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(posedge clk);
      #2;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL midrst_pre cycle %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs !== '0) $display("FAIL midrst_assert: got %h expected %h", obs, '0);
    else passed++;
    @(posedge clk);
    #2;
    total++;
    if (obs !== '0) $display("FAIL midrst_hold: got %h expected %h", obs, '0);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (obs !== '0) $display("FAIL midrst_release: got %h expected %h", obs, '0);
    else passed++;
    exp_q.push_back(mk(3'd1, 2'd0, S_NONE, 1'b0, 1'b0, 4'd1, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd2, 2'd0, S_NONE, 1'b0, 1'b0, 4'd1, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd4, 2'd1, S_RWR,  1'b0, 1'b0, 4'd1, 2'd0, 1'b0));
    exp_q.push_back(mk(3'd0, 2'd0, S_NONE, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL midrst_post cycle %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    drive(2'b00, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_addi();
    test_lw_sw();
    test_beq();
    test_jumps();
    test_stop_bit();
    test_shift_nop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle main control FSM for the simple 32-bit RISC core. It decodes the 2-bit instruction type, 5-bit function and stop bit of the instruction held in the IR. It then sequences FETCH/DECODE/EXEC/MEM/WB, driving PC-source, stack, register-file, ALU and data-memory controls to the datapath. The branch decision uses the ALU zero flag.

Parameters:
none (all encodings fixed below)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
func  in  5  instruction function field
op  in  2  instruction type: 00 R, 01 I, 10 J, 11 S
stop_bit  in  1  instruction stop bit: return via stack after completion
zero  in  1  ALU zero flag, valid in EXEC
PCSrc  out  2  00 hold PC, 01 PC+1, 10 PC+sign-extended offset, 11 stack top
StackRd  out  1  pop return address
StackWr  out  1  push PC+1
RegWr  out  1  register-file write enable
RegSrc  out  1  second read address: 0 Rs2, 1 Rd
ExtOp  out  1  immediate extension: 1 sign, 0 zero
ALUOp  out  4  0000 AND, 0001 ADD, 0010 SUB, 0011 SLL, 0100 SRL
ALUSrc  out  2  ALU operand B: 00 register, 01 extended immediate, 10 shift amount field
MemWr  out  1  data-memory write
MemRd  out  1  data-memory read
WBData  out  1  write-back data: 0 ALU result, 1 memory data

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB. Registered state; all outputs combinational from state, op, func, stop_bit and zero.
- reset low (async): state=FETCH immediately. All outputs 0 while reset is low and in every FETCH cycle.
- FETCH -> DECODE unconditionally.
- Decode fields (RegSrc, ExtOp, ALUOp, ALUSrc, WBData) are driven in every non-FETCH state.
- R-type: func 0 AND, 1 ADD, 2 SUB, 3 CMP. CMP uses ALUOp SUB and no RegWr. ALUSrc=00.
- I-type: func 0 ANDI (ExtOp 0, AND), 1 ADDI (ExtOp 1, ADD), 2 LW, 3 SW, 4 BEQ. LW/SW use ADD with ExtOp 1 and ALUSrc 01. SW and BEQ use RegSrc=1. BEQ uses SUB with ALUSrc=00. LW uses WBData=1.
- J-type: func 0 J, 1 JAL, 2 RET.
- S-type: func 0 SLL, 1 SRL (ALUSrc 10), 2 SLLV, 3 SLRV (ALUSrc 00).
- All other fields not listed are 0.
- Any undefined op/func combination is a NOP: DECODE drives PCSrc=01 and returns to FETCH, with no strobes.
- DECODE:
  - J: PCSrc=10.
  - JAL: StackWr=1, PCSrc=10.
  - RET: StackRd=1, PCSrc=11.
  - All three go to FETCH. All other instructions go to EXEC with PCSrc=00.
- EXEC:
  - BEQ: PCSrc=10 if zero=1, else 01; then FETCH.
  - CMP: completes here (PCSrc per the completion rule below); then FETCH.
  - LW/SW go to MEM. All others go to WB.
- MEM:
  - LW: MemRd=1, then WB.
  - SW: MemWr=1, completes here, then FETCH.
- WB: RegWr=1, completes here, then FETCH.
- Completion rule for non-control-flow instructions (CMP, SW, ALU ops, LW): in the completion cycle, PCSrc=01 if stop_bit=0. If stop_bit=1, PCSrc=11 and StackRd=1.
- stop_bit is ignored for J, JAL, RET and BEQ.
- Latency from FETCH to next FETCH:
  - J/JAL/RET/NOP: 2 cycles
  - BEQ/CMP: 3 cycles
  - ALU R/I/S and SW: 4 cycles
  - LW: 5 cycles
- Strobes (RegWr, MemWr, MemRd, StackRd, StackWr) are each high for exactly one cycle per instruction, and never in FETCH.
- op/func are held stable by the datapath from DECODE to completion.
- Reset asserted mid-instruction aborts the instruction. The next cycle after release is FETCH.

Test Plan:
- reset low 2 cycles, then op=01 func=00001 stop_bit=0 (ADDI) -> FETCH, DECODE, EXEC, WB. WB has RegWr=1, ExtOp=1, ALUSrc=01, ALUOp=0001, PCSrc=01; all outputs 0 during reset and FETCH.
- op=01 func=00010 (LW) -> MEM cycle MemRd=1; WB cycle RegWr=1, WBData=1; 5-cycle period. op=01 func=00011 (SW) -> MEM cycle MemWr=1, RegSrc=1, PCSrc=01; RegWr never asserted.
- op=01 func=00100 (BEQ) with zero=1 -> EXEC PCSrc=10. With zero=0 -> PCSrc=01. ALUOp=0010, RegSrc=1, no strobes.
- op=10 func 0/1/2 -> DECODE PCSrc=10 / StackWr=1, PCSrc=10 / StackRd=1, PCSrc=11; next cycle FETCH.
- op=00 func=00001 stop_bit=1 -> WB RegWr=1, StackRd=1, PCSrc=11. op=11 func=00000 -> ALUSrc=10, ALUOp=0011. op=00 func=11111 -> NOP, PCSrc=01 in DECODE.
- Assert reset during EXEC of ADD -> outputs 0 immediately, no RegWr. Release -> FETCH.
